// File: rtl/timer_pkg.sv
// timer_pkg: shared mode encodings, sequencer states and default timing constants
package timer_pkg;
  typedef enum logic [1:0] {
    MODE_RUN     = 2'b00,
    MODE_ISTOP   = 2'b01,
    MODE_STEP    = 2'b10,
    MODE_RUN_ALT = 2'b11
  } mode_e;
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_STOP = 1'b1
  } seq_st_e;
  localparam int NT_DEF     = 12;
  localparam int NPH_DEF    = 4;
  localparam int WT_PH_DEF  = 1;
  localparam int CT_PH_DEF  = 2;
  localparam int OVF_TP_DEF = 10;
endpackage

// File: rtl/tp_ring.sv
// tp_ring: timepulse/phase counter with tick enable, synchronous load and end-of-timepulse wrap flag
module tp_ring
  import timer_pkg::*;
#(
  parameter int NT  = NT_DEF,
  parameter int NPH = NPH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic                  ld_i,
  input  logic [$clog2(NT)-1:0] ld_tp_i,
  output logic [$clog2(NT)-1:0] tp_o,
  output logic [$clog2(NPH)-1:0] ph_o,
  output logic                  wrap_o
);
  localparam int TW = $clog2(NT);
  localparam int PW = $clog2(NPH);
  logic [TW-1:0] tp_q, tp_d;
  logic [PW-1:0] ph_q, ph_d;
  assign wrap_o = en_i & (ph_q == PW'(NPH-1));
  assign tp_o = tp_q;
  assign ph_o = ph_q;
  // load parks at phase 0 of the given timepulse; otherwise a tick advances the phase and wraps into the next timepulse
  always_comb begin
    ph_d = ld_i ? '0 : wrap_o ? '0 : en_i ? ph_q + 1'b1 : ph_q;
    tp_d = ld_i ? ld_tp_i : !wrap_o ? tp_q : (tp_q == TW'(NT-1)) ? '0 : tp_q + 1'b1;
  end
  // counter registers, reset to the last timepulse so the first wrap lands on timepulse 0
  always_ff @(posedge clk) begin
    if (rst) begin
      tp_q <= TW'(NT-1);
      ph_q <= '0;
    end else begin
      tp_q <= tp_d;
      ph_q <= ph_d;
    end
  end
endmodule

// File: rtl/timepulse_seq.sv
// timepulse_seq: timepulse/phase sequencer with stop/step modes, GOJAM restart and overflow sampling
module timepulse_seq
  import timer_pkg::*;
#(
  parameter int NT     = NT_DEF,
  parameter int NPH    = NPH_DEF,
  parameter int WT_PH  = WT_PH_DEF,
  parameter int CT_PH  = CT_PH_DEF,
  parameter int OVF_TP = OVF_TP_DEF
) (
  input  logic                  SIM_CLK,
  input  logic                  SIM_RST,
  input  logic                  CLOCK,
  input  logic [1:0]            MODE,
  input  logic                  MSTRTP,
  input  logic                  GOJ1,
  input  logic                  WL15,
  input  logic                  WL16,
  output logic [NT-1:0]         T,
  output logic [NPH-1:0]        PHS,
  output logic [$clog2(NT)-1:0] TIDX,
  output logic                  WT,
  output logic                  CT,
  output logic                  STOP,
  output logic                  GOJAM,
  output logic                  OVF_n,
  output logic                  UNF_n
);
  localparam int TW = $clog2(NT);
  localparam int PW = $clog2(NPH);
  seq_st_e st_q, st_d;
  logic gojam_q, gojam_d, ovf_n_q, ovf_n_d, unf_n_q, unf_n_d, mstrtp_q;
  logic [TW-1:0] tp;
  logic [PW-1:0] ph;
  logic wrap, run, rise, last_tp, halt;
  mode_e mode;
  assign mode = mode_e'(MODE);
  assign run = st_q == ST_RUN;
  assign rise = MSTRTP & ~mstrtp_q;
  assign last_tp = tp == TW'(NT-1);
  assign halt = wrap & ((mode == MODE_STEP) | ((mode == MODE_ISTOP) & last_tp));
  tp_ring #(.NT(NT), .NPH(NPH)) u_ring (
    .clk    (SIM_CLK),
    .rst    (SIM_RST),
    .en_i   (run & CLOCK),
    .ld_i   (GOJ1),
    .ld_tp_i(TW'(NT-1)),
    .tp_o   (tp),
    .ph_o   (ph),
    .wrap_o (wrap)
  );
  // GOJ1 beats everything; a halting wrap stops; a stopped sequencer resumes only on an MSTRTP rise
  always_comb begin
    st_d    = GOJ1 ? ST_RUN : halt ? ST_STOP : (!run && rise) ? ST_RUN : st_q;
    gojam_d = GOJ1 | (gojam_q & ~(wrap & last_tp));
    T       = run ? NT'(1) << tp : '0;
    PHS     = run ? NPH'(1) << ph : '0;
    TIDX    = tp;
    WT      = run & CLOCK & (ph == PW'(WT_PH));
    CT      = run & CLOCK & (ph == PW'(CT_PH));
    STOP    = !run;
    GOJAM   = gojam_q;
    OVF_n   = ovf_n_q;
    UNF_n   = unf_n_q;
    ovf_n_d = (CT && tp == TW'(OVF_TP)) ? ~(~WL16 & WL15) : ovf_n_q;
    unf_n_d = (CT && tp == TW'(OVF_TP)) ? ~(WL16 & ~WL15) : unf_n_q;
  end
  // control registers; the MSTRTP history runs every cycle so edges are never missed while the oscillator idles
  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      st_q     <= ST_RUN;
      gojam_q  <= 1'b1;
      ovf_n_q  <= 1'b1;
      unf_n_q  <= 1'b1;
      mstrtp_q <= 1'b0;
    end else begin
      st_q     <= st_d;
      gojam_q  <= gojam_d;
      ovf_n_q  <= ovf_n_d;
      unf_n_q  <= unf_n_d;
      mstrtp_q <= MSTRTP;
    end
  end
endmodule
